// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial lane scheduler.
package serial_pkg;

  localparam int unsigned NumLanes     = 4;
  localparam int unsigned LaneW        = 2;
  localparam int unsigned SyncSlotsDef = 4;
  localparam logic [7:0]  IdleSymDef   = 8'hBC;

  typedef enum logic [0:0] {
    StSync   = 1'b0,
    StActive = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 4-way round-robin arbiter; search starts at last+1 and wraps.
module rr_arbiter
  import serial_pkg::*;
(
  input  logic [NumLanes-1:0] req,
  input  logic [LaneW-1:0]    last,
  output logic [NumLanes-1:0] gnt,
  output logic [LaneW-1:0]    idx
);

  logic [LaneW-1:0] cand;

  // First requester found after the previous winner takes the grant.
  always_comb begin
    gnt  = '0;
    idx  = last;
    cand = '0;
    for (int unsigned k = 1; k <= NumLanes; k++) begin
      cand = last + LaneW'(k);
      if (req[cand] && (gnt == '0)) begin
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/serial_lane_sched.sv
// Slot scheduler: emits idle sync slots after reset, then grants one lane
// byte per 8-cycle slot to the serializer by round-robin.
module serial_lane_sched
  import serial_pkg::*;
#(
  parameter int unsigned SYNC_SLOTS = SyncSlotsDef,
  parameter logic [7:0]  IDLE_SYM   = IdleSymDef
) (
  input  logic                  clk8f,
  input  logic                  reset_L,
  input  logic                  en,
  input  logic [NumLanes-1:0]   req_valid,
  input  logic [8*NumLanes-1:0] req_data,
  output logic [NumLanes-1:0]   req_ready,
  output logic [8:0]            paralelo,
  output logic [2:0]            bit_idx,
  output logic                  slot_start,
  output logic                  active,
  output logic [LaneW-1:0]      cur_lane
);

  localparam int unsigned CntW = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS) : 1;

  state_e            state_q, state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CntW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [8:0]        par_q, par_d;
  logic [LaneW-1:0]  last_q, last_d;
  logic [LaneW-1:0]  cur_q, cur_d;

  logic                slot_end;
  logic                sync_done;
  logic                grant_ok;
  logic [NumLanes-1:0] gnt;
  logic [LaneW-1:0]    gnt_idx;

  assign slot_end  = (bit_idx_q == 3'd7);
  assign sync_done = (sync_cnt_q == CntW'(SYNC_SLOTS - 1));

  rr_arbiter u_rr_arbiter (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // FSM state register.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) state_q <= StSync;
    else          state_q <= state_d;
  end

  // FSM next state: leave SYNC at the end of the last sync slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync:   if (slot_end && sync_done) state_d = StActive;
      StActive: state_d = StActive;
      default:  state_d = StSync;
    endcase
  end

  // FSM outputs: grants only at slot end in ACTIVE with enable.
  always_comb begin
    active    = (state_q == StActive);
    grant_ok  = active && slot_end && en && (req_valid != '0);
    req_ready = grant_ok ? gnt : '0;
  end

  // Datapath next state: slot counter, sync count and slot word.
  always_comb begin
    bit_idx_d  = bit_idx_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    par_d      = par_q;
    last_d     = last_q;
    cur_d      = cur_q;
    if ((state_q == StSync) && slot_end && !sync_done) begin
      sync_cnt_d = sync_cnt_q + CntW'(1);
    end
    if (slot_end) begin
      if (grant_ok) begin
        par_d  = {1'b1, req_data[{gnt_idx, 3'b000} +: 8]};
        last_d = gnt_idx;
        cur_d  = gnt_idx;
      end else begin
        par_d = {1'b0, IDLE_SYM};
      end
    end
  end

  // Datapath registers; last grant resets to the top lane so lane 0 wins first.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_idx_q  <= '0;
      sync_cnt_q <= '0;
      par_q      <= {1'b0, IDLE_SYM};
      last_q     <= LaneW'(NumLanes - 1);
      cur_q      <= '0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      sync_cnt_q <= sync_cnt_d;
      par_q      <= par_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
    end
  end

  assign paralelo   = par_q;
  assign bit_idx    = bit_idx_q;
  assign slot_start = (bit_idx_q == 3'd0);
  assign cur_lane   = cur_q;

endmodule

// File: tb/tb_serial_lane_sched.sv
// Bench for serial_lane_sched: cycle-level model plus directed scenarios.
module tb_serial_lane_sched;

  localparam int SyncSlots = 4;
  localparam int SyncCyc   = 8 * SyncSlots;

  logic        clk8f = 1'b0;
  logic        reset_L;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [8:0]  paralelo;
  logic [2:0]  bit_idx;
  logic        slot_start;
  logic        active;
  logic [1:0]  cur_lane;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk8f = ~clk8f;

  serial_lane_sched dut (
    .clk8f      (clk8f),
    .reset_L    (reset_L),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .paralelo   (paralelo),
    .bit_idx    (bit_idx),
    .slot_start (slot_start),
    .active     (active),
    .cur_lane   (cur_lane)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time since reset release in clock edges; slot position and mode follow from it.
  int         m_cyc  = 0;
  logic [8:0] m_par  = 9'h0BC;
  logic [1:0] m_last = 2'd3;
  logic [1:0] m_cur  = 2'd0;
  int         mg;

  function automatic int pick(input logic [1:0] last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int l;
      l = (int'(last) + k) % 4;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int g;
    r = '0;
    if (m_cyc >= SyncCyc && (m_cyc % 8) == 7 && en) begin
      g = pick(m_last, req_valid);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      m_cyc  <= 0;
      m_par  <= 9'h0BC;
      m_last <= 2'd3;
      m_cur  <= 2'd0;
    end else begin
      if ((m_cyc % 8) == 7) begin
        mg = (m_cyc >= SyncCyc && en) ? pick(m_last, req_valid) : -1;
        if (mg >= 0) begin
          m_par  <= {1'b1, req_data[8*mg +: 8]};
          m_last <= 2'(mg);
          m_cur  <= 2'(mg);
        end else begin
          m_par <= 9'h0BC;
        end
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk8f) begin
    chk("paralelo", 32'(paralelo), 32'(m_par));
    chk("bit_idx", 32'(bit_idx), 32'(m_cyc % 8));
    chk("slot_start", 32'(slot_start), 32'((m_cyc % 8) == 0));
    chk("active", 32'(active), 32'(m_cyc >= SyncCyc));
    chk("cur_lane", 32'(cur_lane), 32'(m_cur));
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
  end

  task automatic wait_bit(input int b);
    int n;
    n = 0;
    while ((m_cyc % 8) != b && n < 16) begin
      @(posedge clk8f);
      #1;
      n++;
    end
    if ((m_cyc % 8) != b) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_bit: got %0d expected %0d", m_cyc % 8, b);
    end
  endtask

  // ---------------- directed scenarios ----------------
  logic [8:0] rr_exp [5];
  int n;

  initial begin
    rr_exp[0] = 9'h110; rr_exp[1] = 9'h111; rr_exp[2] = 9'h112;
    rr_exp[3] = 9'h113; rr_exp[4] = 9'h110;
    reset_L   = 1'b1;
    en        = 1'b1;
    req_valid = 4'h0;
    req_data  = 32'h0;
    #1 reset_L = 1'b0;
    #1;
    chk("rst_paralelo", 32'(paralelo), 32'h0BC);
    chk("rst_bit_idx", 32'(bit_idx), 32'h0);
    chk("rst_slot_start", 32'(slot_start), 32'h1);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_cur_lane", 32'(cur_lane), 32'h0);
    #10 reset_L = 1'b1;

    // Sync: four idle slots, active only after 32 cycles.
    repeat (31) @(posedge clk8f);
    #1;
    chk("sync_active_c31", 32'(active), 32'h0);
    chk("sync_idle", 32'(paralelo), 32'h0BC);
    @(posedge clk8f);
    #1;
    chk("sync_active_c32", 32'(active), 32'h1);
    chk("sync_bit0", 32'(bit_idx), 32'h0);

    // All lanes valid: strict rotation starting at lane 0.
    req_data  = 32'h13121110;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_bit(7);
      if (i == 0) chk("rr_first_ready", 32'(req_ready), 32'h1);
      @(posedge clk8f);
      #1;
      chk("rr_slot", 32'(paralelo), 32'(rr_exp[i]));
    end
    req_valid = 4'h0;

    // Single lane 2 request.
    req_data  = 32'h135A1110;
    req_valid = 4'b0100;
    wait_bit(7);
    chk("l2_ready", 32'(req_ready), 32'b0100);
    @(posedge clk8f);
    #1;
    req_valid = 4'h0;
    chk("l2_paralelo", 32'(paralelo), 32'h15A);
    chk("l2_cur_lane", 32'(cur_lane), 32'h2);

    // Enable low blocks grants; re-enabling grants lane 0 first.
    en        = 1'b0;
    req_data  = 32'h13121110;
    req_valid = 4'b0011;
    repeat (2) begin
      wait_bit(7);
      chk("en0_ready", 32'(req_ready), 32'h0);
      @(posedge clk8f);
      #1;
      chk("en0_idle", 32'(paralelo), 32'h0BC);
      chk("en0_cur_hold", 32'(cur_lane), 32'h2);
    end
    en = 1'b1;
    wait_bit(7);
    chk("en1_ready", 32'(req_ready), 32'b0001);
    @(posedge clk8f);
    #1;
    chk("en1_paralelo", 32'(paralelo), 32'h110);
    req_valid = 4'b0010;

    // Enable falling mid-slot leaves the current slot untouched.
    wait_bit(3);
    en = 1'b0;
    wait_bit(5);
    chk("en_mid_hold", 32'(paralelo), 32'h110);
    wait_bit(7);
    chk("en_mid_ready", 32'(req_ready), 32'h0);
    @(posedge clk8f);
    #1;
    chk("en_mid_idle", 32'(paralelo), 32'h0BC);
    en        = 1'b1;
    req_valid = 4'h0;

    // Asynchronous reset in the middle of a data slot.
    req_data  = 32'h77000000;
    req_valid = 4'b1000;
    wait_bit(7);
    @(posedge clk8f);
    #1;
    chk("pre_rst_data", 32'(paralelo), 32'h177);
    wait_bit(3);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_paralelo", 32'(paralelo), 32'h0BC);
    chk("async_rst_bit_idx", 32'(bit_idx), 32'h0);
    #10 reset_L = 1'b1;
    n = 0;
    while (req_ready == 4'h0 && n < 100) begin
      @(posedge clk8f);
      #1;
      n++;
    end
    chk("regrant_latency", 32'(n), 32'd39);
    chk("regrant_ready", 32'(req_ready), 32'b1000);
    @(posedge clk8f);
    #1;
    chk("regrant_paralelo", 32'(paralelo), 32'h177);
    req_valid = 4'h0;
    repeat (10) @(posedge clk8f);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
